// File: rtl/softmax_drv_pkg.sv
// rtl/softmax_drv_pkg.sv - state encoding and sizing helpers for the softmax row driver
package softmax_drv_pkg;

  localparam int D_W_DEF     = 8;
  localparam int NUM_DEF     = 16;
  localparam int TIMEOUT_DEF = 64;

  function automatic int idx_w(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

  localparam int IDX_W = idx_w(NUM_DEF);

  typedef enum logic [3:0] {
    S_LOAD  = 4'b0001,
    S_START = 4'b0010,
    S_RUN   = 4'b0100,
    S_DRAIN = 4'b1000
  } state_t;

endpackage

// File: rtl/softmax_row_driver_if.sv
// rtl/softmax_row_driver_if.sv - score stream, engine handshake and weight stream of the softmax row driver
interface softmax_row_driver_if #(
  parameter int D_W = 8,
  parameter int NUM = 16
);

  logic                    in_vld;
  logic                    in_rdy;
  logic [D_W-1:0]          in_data;
  logic                    sm_start;
  logic [NUM-1:0][D_W-1:0] sm_data;
  logic                    sm_vld;
  logic [NUM-1:0][D_W-1:0] sm_result;
  logic                    out_vld;
  logic                    out_rdy;
  logic [D_W-1:0]          out_data;
  logic                    out_last;
  logic                    busy;
  logic                    err;

  modport master (
    input  in_vld, in_data, sm_vld, sm_result, out_rdy,
    output in_rdy, sm_start, sm_data, out_vld, out_data, out_last, busy, err
  );

  modport slave (
    output in_vld, in_data, sm_vld, sm_result, out_rdy,
    input  in_rdy, sm_start, sm_data, out_vld, out_data, out_last, busy, err
  );

endinterface

// File: rtl/sm_row_pack.sv
// rtl/sm_row_pack.sv - serial-to-parallel row buffer with its own write index
module sm_row_pack
  import softmax_drv_pkg::*;
#(
  parameter int D_W = D_W_DEF,
  parameter int NUM = NUM_DEF,
  parameter int IW  = IDX_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [D_W-1:0]          wr_data,
  output logic [NUM-1:0][D_W-1:0] row,
  output logic                    wr_last
);

  logic [IW-1:0] idx;

  // NUM is a power of two, so the natural wrap of idx is the NUM-1 -> 0 wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
      row <= '0;
    end else if (wr_en) begin
      row[idx] <= wr_data;
      idx      <= idx + 1'b1;
    end
  end

  assign wr_last = (idx == IW'(NUM - 1));

endmodule

// File: rtl/softmax_row_driver.sv
// rtl/softmax_row_driver.sv - packs a score row, runs the softmax engine, replays the result row
// Optional: SOFTMAX_DRV_TIMEOUT_EN adds an engine watchdog with a sticky err flag.
module softmax_row_driver
  import softmax_drv_pkg::*;
#(
  parameter int D_W     = D_W_DEF,
  parameter int NUM     = NUM_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  softmax_row_driver_if.master bus
);

  localparam int            IW       = idx_w(NUM);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM - 1);

  if (NUM < 2 || (NUM & (NUM - 1)) != 0 || TIMEOUT < 2) begin : g_param_check
    $error("softmax_row_driver: NUM must be a power of 2 >= 2 and TIMEOUT >= 2");
  end

  typedef logic [NUM-1:0][D_W-1:0] row_t;

  state_t         state, state_d;
  logic [IW-1:0]  idx, idx_d, idx_nxt;
  logic [1:0]     gap, gap_d;
  logic           in_rdy, in_rdy_d;
  logic           sm_start, sm_start_d;
  logic           out_vld, out_vld_d;
  logic           out_last, out_last_d;
  logic           busy, busy_d;
  logic           err, err_d;
  logic [D_W-1:0] out_data, out_data_d;
  row_t           res, res_d, row;
  logic           in_hs, out_hs, wr_last, timeout_hit;

  assign in_hs   = (state == S_LOAD) && in_rdy && bus.in_vld;
  assign out_hs  = (state == S_DRAIN) && out_vld && bus.out_rdy;
  assign idx_nxt = idx + 1'b1;

  sm_row_pack #(
    .D_W (D_W),
    .NUM (NUM),
    .IW  (IW)
  ) u_pack (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_hs),
    .wr_data (bus.in_data),
    .row     (row),
    .wr_last (wr_last)
  );

`ifdef SOFTMAX_DRV_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  logic [WD_W-1:0] wdog;

  // Held at zero outside S_RUN, so it is already clear on the first S_RUN cycle
  always_ff @(posedge clk) begin
    if (!rst_n || state != S_RUN) wdog <= '0;
    else                          wdog <= wdog + 1'b1;
  end

  assign timeout_hit = (wdog == WD_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state;
    idx_d      = idx;
    gap_d      = (state != S_RUN && gap != 2'd2) ? gap + 2'd1 : gap;
    in_rdy_d   = in_rdy;
    sm_start_d = sm_start;
    out_vld_d  = out_vld;
    out_data_d = out_data;
    out_last_d = out_last;
    err_d      = err;
    res_d      = res;
    case (state)
      S_LOAD: begin
        if (in_hs && wr_last) begin
          in_rdy_d = 1'b0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (gap == 2'd2) begin
          sm_start_d = 1'b1;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        // The engine drops its result the cycle after the pulse, so capture now
        if (bus.sm_vld) begin
          res_d      = bus.sm_result;
          out_data_d = bus.sm_result[0];
          out_vld_d  = 1'b1;
          out_last_d = 1'b0;
          sm_start_d = 1'b0;
          gap_d      = 2'd0;
          idx_d      = '0;
          state_d    = S_DRAIN;
        end else if (timeout_hit) begin
          res_d      = '0;
          out_data_d = '0;
          out_vld_d  = 1'b1;
          out_last_d = 1'b0;
          sm_start_d = 1'b0;
          gap_d      = 2'd0;
          err_d      = 1'b1;
          idx_d      = '0;
          state_d    = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_hs) begin
          if (idx == LAST_IDX) begin
            idx_d      = '0;
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
            out_data_d = '0;
            in_rdy_d   = 1'b1;
            state_d    = S_LOAD;
          end else begin
            idx_d      = idx_nxt;
            out_data_d = res[idx_nxt];
            out_last_d = (idx_nxt == LAST_IDX);
          end
        end
      end
      default: begin
        idx_d      = '0;
        in_rdy_d   = 1'b1;
        sm_start_d = 1'b0;
        out_vld_d  = 1'b0;
        out_last_d = 1'b0;
        state_d    = S_LOAD;
      end
    endcase
    busy_d = (state_d != S_LOAD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_LOAD;
      idx      <= '0;
      gap      <= 2'd0;
      in_rdy   <= 1'b1;
      sm_start <= 1'b0;
      out_vld  <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      res      <= '0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      gap      <= gap_d;
      in_rdy   <= in_rdy_d;
      sm_start <= sm_start_d;
      out_vld  <= out_vld_d;
      out_data <= out_data_d;
      out_last <= out_last_d;
      busy     <= busy_d;
      err      <= err_d;
      res      <= res_d;
    end
  end

  assign bus.in_rdy   = in_rdy;
  assign bus.sm_start = sm_start;
  assign bus.sm_data  = row;
  assign bus.out_vld  = out_vld;
  assign bus.out_data = out_data;
  assign bus.out_last = out_last;
  assign bus.busy     = busy;
  assign bus.err      = err;

endmodule

// File: tb/tb_softmax_row_driver.sv
// tb/tb_softmax_row_driver.sv - directed bench for softmax_row_driver with a softmax engine stub
`timescale 1ns/1ps
module tb_softmax_row_driver;

  localparam int D_W = 8;
  localparam int NUM = 16;
  localparam int LAT = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  softmax_row_driver_if #(.D_W(D_W), .NUM(NUM)) bus();

  softmax_row_driver #(.D_W(D_W), .NUM(NUM), .TIMEOUT(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine stub: pulses valid LAT cycles after start rises, result = data ^ FF
  logic                    stub_en    = 1'b1;
  int                      stub_cnt   = 0;
  logic                    stub_vld   = 1'b0;
  logic [NUM-1:0][D_W-1:0] stub_data  = '0;
  logic                    force_vld  = 1'b0;
  logic [NUM-1:0][D_W-1:0] force_data = '0;

  assign bus.sm_vld    = stub_vld | force_vld;
  assign bus.sm_result = force_vld ? force_data : stub_data;

  always @(posedge clk) begin
    if (!bus.sm_start) begin
      stub_cnt  <= 0;
      stub_vld  <= 1'b0;
      stub_data <= '0;
    end else begin
      stub_cnt <= stub_cnt + 1;
      if (stub_en && stub_cnt == LAT) begin
        stub_vld <= 1'b1;
        for (int i = 0; i < NUM; i++) stub_data[i] <= bus.sm_data[i] ^ 8'hFF;
      end else begin
        stub_vld  <= 1'b0;
        stub_data <= '0;
      end
    end
  end

  logic                    prev_start = 1'b0;
  int                      low_cnt = 0, high_cnt = 0, rise_gap = 0, last_high = 0, rises = 0, data_moves = 0;
  logic [NUM-1:0][D_W-1:0] held = '0;

  always @(negedge clk) begin
    prev_start <= bus.sm_start;
    if (bus.sm_start) begin
      low_cnt <= 0;
      if (!prev_start) begin
        rise_gap <= low_cnt;
        high_cnt <= 1;
        held     <= bus.sm_data;
        rises    <= rises + 1;
      end else begin
        high_cnt <= high_cnt + 1;
        if (bus.sm_data !== held) data_moves <= data_moves + 1;
      end
    end else begin
      low_cnt <= low_cnt + 1;
      if (prev_start) last_high <= high_cnt;
    end
  end

  task automatic send_row(input logic [7:0] d[NUM], input int spur_at, output int last_cyc);
    int w;
    last_cyc = 0;
    for (int i = 0; i < NUM; i++) begin
      @(negedge clk);
      force_vld   = 1'b0;
      bus.in_vld  = 1'b1;
      bus.in_data = d[i];
      if (i == spur_at) begin
        force_vld  = 1'b1;
        force_data = {NUM{8'hA5}};
      end
      w = 0;
      while (bus.in_rdy !== 1'b1 && w < 100) begin
        @(negedge clk);
        force_vld = 1'b0;
        w++;
      end
      if (w >= 100) begin
        checks++;
        errors++;
        $display("FAIL send_row word %0d: in_rdy=%b, required 1", i, bus.in_rdy);
        bus.in_vld = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_vld = 1'b0;
    force_vld  = 1'b0;
    last_cyc   = cyc;
  endtask

  task automatic recv_row(input logic [7:0] e[NUM], input bit toggle, input string tag, output int first_cyc);
    int       got = 0, n = 0, bad_rdy = 0;
    logic     pend = 1'b0, pl = 1'b0;
    logic [7:0] pd = '0;
    first_cyc = -1;
    while (got < NUM && n < 600) begin
      @(negedge clk);
      bus.out_rdy = toggle ? ~n[0] : 1'b1;
      if (bus.in_rdy !== 1'b0) bad_rdy++;
      if (pend) begin
        checks++;
        if (bus.out_data !== pd || bus.out_last !== pl) begin
          errors++;
          $display("FAIL %s hold: data=%h last=%b, required data=%h last=%b", tag, bus.out_data, bus.out_last, pd, pl);
        end
      end
      pend = 1'b0;
      if (bus.out_vld === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (bus.out_rdy) begin
          checks++;
          if (bus.out_data !== e[got] || bus.out_last !== (got == NUM - 1)) begin
            errors++;
            $display("FAIL %s word %0d: data=%h last=%b, required data=%h last=%b", tag, got, bus.out_data, bus.out_last, e[got], (got == NUM - 1));
          end
          got++;
        end else begin
          pend = 1'b1;
          pd   = bus.out_data;
          pl   = bus.out_last;
        end
      end
      n++;
    end
    checks++;
    if (got !== NUM) begin
      errors++;
      $display("FAIL %s count: got %0d words, required %0d", tag, got, NUM);
    end
    checks++;
    if (bad_rdy !== 0) begin
      errors++;
      $display("FAIL %s in_rdy_low: %0d cycles with in_rdy!=0, required 0", tag, bad_rdy);
    end
    @(negedge clk);
    bus.out_rdy = 1'b1;
    checks++;
    if ({bus.in_rdy, bus.out_vld, bus.busy} !== 3'b100) begin
      errors++;
      $display("FAIL %s idle_after: in_rdy/out_vld/busy=%b, required 100", tag, {bus.in_rdy, bus.out_vld, bus.busy});
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.in_rdy, bus.sm_start, bus.out_vld, bus.out_last, bus.busy, bus.err} !== 6'b100000) begin
      errors++;
      $display("FAIL reset flags: %b, required 100000", {bus.in_rdy, bus.sm_start, bus.out_vld, bus.out_last, bus.busy, bus.err});
    end
    checks++;
    if (bus.sm_data !== '0 || bus.out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset data: sm_data=%h out_data=%h, required 0 0", bus.sm_data, bus.out_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.in_rdy, bus.busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset release: in_rdy/busy=%b, required 10", {bus.in_rdy, bus.busy});
    end
  endtask

  task automatic test_basic;
    logic [7:0] d[NUM], e[NUM];
    int lc, fc;
    for (int i = 0; i < NUM; i++) begin
      d[i] = 8'(i);
      e[i] = 8'(8'hFF - i);
    end
    send_row(d, -1, lc);
    recv_row(e, 1'b0, "basic", fc);
    checks++;
    if (fc - lc !== 8) begin
      errors++;
      $display("FAIL basic latency: %0d cycles, required 8", fc - lc);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] d[NUM], e[NUM];
    int lc, fc;
    for (int i = 0; i < NUM; i++) begin
      d[i] = 8'(8'h3C + 7 * i);
      e[i] = ~d[i];
    end
    send_row(d, -1, lc);
    recv_row(e, 1'b1, "backpressure", fc);
  endtask

  task automatic test_back_to_back;
    logic [7:0] a[NUM], ea[NUM], b[NUM], eb[NUM];
    int lc, fc, r0, m0;
    for (int i = 0; i < NUM; i++) begin
      a[i]  = 8'(8'h80 + i);
      ea[i] = 8'(8'h7F - i);
      b[i]  = 8'(8'hF0 - 16 * i);
      eb[i] = ~b[i];
    end
    r0 = rises;
    m0 = data_moves;
    send_row(a, -1, lc);
    recv_row(ea, 1'b0, "b2b_a", fc);
    send_row(b, -1, lc);
    recv_row(eb, 1'b0, "b2b_b", fc);
    checks++;
    if (rises - r0 !== 2) begin
      errors++;
      $display("FAIL b2b start_rises: %0d, required 2", rises - r0);
    end
    checks++;
    if (rise_gap < 2) begin
      errors++;
      $display("FAIL b2b start_gap: %0d low cycles, required >= 2", rise_gap);
    end
    checks++;
    if (data_moves - m0 !== 0) begin
      errors++;
      $display("FAIL b2b sm_data_frozen: %0d changes while start high, required 0", data_moves - m0);
    end
  endtask

  task automatic test_spurious;
    logic [7:0] d[NUM], e[NUM];
    int lc, fc;
    for (int i = 0; i < NUM; i++) begin
      d[i] = 8'(8'h55 ^ (i * 3));
      e[i] = ~d[i];
    end
    send_row(d, 5, lc);
    recv_row(e, 1'b0, "spurious", fc);
  endtask

  task automatic test_reset_in_run;
    logic [7:0] d[NUM], e[NUM];
    int lc, fc, w, vld_seen, rdy_low;
    for (int i = 0; i < NUM; i++) begin
      d[i] = 8'(8'hC3 + i);
      e[i] = ~d[i];
    end
    stub_en = 1'b0;
    send_row(d, -1, lc);
    w = 0;
    while (bus.sm_start !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    checks++;
    if ({bus.sm_start, bus.busy} !== 2'b11) begin
      errors++;
      $display("FAIL run_state: start/busy=%b, required 11", {bus.sm_start, bus.busy});
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    force_vld  = 1'b1;
    force_data = {NUM{8'h3E}};
    @(negedge clk);
    force_vld = 1'b0;
    vld_seen  = 0;
    rdy_low   = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_vld !== 1'b0) vld_seen++;
      if (bus.in_rdy !== 1'b1) rdy_low++;
    end
    checks++;
    if (vld_seen !== 0 || rdy_low !== 0) begin
      errors++;
      $display("FAIL reset_in_run idle: out_vld cycles=%0d in_rdy low cycles=%0d, required 0 0", vld_seen, rdy_low);
    end
    checks++;
    if (bus.sm_start !== 1'b0 || bus.sm_data !== '0) begin
      errors++;
      $display("FAIL reset_in_run engine: start=%b sm_data=%h, required 0 0", bus.sm_start, bus.sm_data);
    end
    stub_en = 1'b1;
    send_row(d, -1, lc);
    recv_row(e, 1'b0, "after_reset", fc);
  endtask

`ifdef SOFTMAX_DRV_TIMEOUT_EN
  task automatic test_timeout;
    logic [7:0] d[NUM], z[NUM];
    int lc, fc;
    for (int i = 0; i < NUM; i++) begin
      d[i] = 8'(8'h11 * i);
      z[i] = 8'h00;
    end
    stub_en = 1'b0;
    send_row(d, -1, lc);
    recv_row(z, 1'b0, "timeout", fc);
    checks++;
    if (last_high !== 64) begin
      errors++;
      $display("FAIL timeout start_high: %0d cycles, required 64", last_high);
    end
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL timeout err: %b, required 1", bus.err);
    end
    stub_en = 1'b1;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL timeout err_cleared: %b, required 0", bus.err);
    end
  endtask
`else
  task automatic test_err_tied;
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL err_tied: %b, required 0", bus.err);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.in_vld  = 1'b0;
    bus.in_data = '0;
    bus.out_rdy = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_spurious();
    test_reset_in_run();
`ifdef SOFTMAX_DRV_TIMEOUT_EN
    test_timeout();
`else
    test_err_tied();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
